// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdc_pkg
// Purpose  : Shared tap/count widths, chunking helper and FSM encoding for the
//            TDC thermometer encoder and decoder.
// Revision : 1.0  initial release
// ============================================================================
package tdc_pkg;

    localparam int c_num_taps   = 300;
    localparam int c_num_decode = 10;
    localparam int c_chunk      = 32;

    function automatic int nchunk(input int taps, input int chunk);
        return (taps + chunk - 1) / chunk;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/thermo_encode_if.sv
`default_nettype none
// ============================================================================
// Module   : thermo_encode_if
// Purpose  : Request/result bundle between a thermometer encoder and its user.
// Revision : 1.0  initial release
// ============================================================================
interface thermo_encode_if
    import tdc_pkg::*;
#(
    parameter int NUM_TAPS   = c_num_taps,
    parameter int NUM_DECODE = c_num_decode
) ();

    logic                  go;
    logic [NUM_DECODE-1:0] wEncodeIn;
    logic                  busy;
    logic                  finished;
    logic [NUM_TAPS-1:0]   wEncodeOut;

    modport master (
        output go,
        output wEncodeIn,
        input  busy,
        input  finished,
        input  wEncodeOut
    );

    modport slave (
        input  go,
        input  wEncodeIn,
        output busy,
        output finished,
        output wEncodeOut
    );

endinterface
`default_nettype wire

// File: rtl/thermo_chunk.sv
`default_nettype none
// ============================================================================
// Module   : thermo_chunk
// Purpose  : Combinational thermometer mask for one CHUNK-wide slice of taps.
// Revision : 1.0  initial release
// ============================================================================
module thermo_chunk
    import tdc_pkg::*;
#(
    parameter int NUM_TAPS = c_num_taps,
    parameter int CMP_W    = c_num_decode + 1,
    parameter int CHUNK    = c_chunk
) (
    input  wire logic [CMP_W-1:0] i_base,
    input  wire logic [CMP_W-1:0] i_nsat,
    input  wire logic             i_falling,
    output logic      [CHUNK-1:0] o_mask
);

    localparam logic [CMP_W-1:0] c_taps = CMP_W'(NUM_TAPS);

    // Lowest lit tap when ones grow down from the top of the chain.
    logic [CMP_W-1:0] w_lo;
    assign w_lo = c_taps - i_nsat;

    for (genvar g = 0; g < CHUNK; g++) begin : g_tap
        logic [CMP_W-1:0] w_tap;
        assign w_tap     = i_base + CMP_W'(g);
        assign o_mask[g] = (w_tap < c_taps) &&
                           (i_falling ? (w_tap >= w_lo) : (w_tap < i_nsat));
    end

endmodule
`default_nettype wire

// File: rtl/thermo_encode.sv
`default_nettype none
// ============================================================================
// Module   : thermo_encode
// Purpose  : Binary count to thermometer word, built CHUNK taps per cycle.
// Revision : 1.0  initial release
// ============================================================================
module thermo_encode
    import tdc_pkg::*;
#(
    parameter int   NUM_TAPS   = c_num_taps,
    parameter int   NUM_DECODE = c_num_decode,
    parameter int   CHUNK      = c_chunk,
    parameter logic FALLING    = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    thermo_encode_if.slave  bus
);

    localparam int c_nchunk = nchunk(NUM_TAPS, CHUNK);
    localparam int c_cnt_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
    localparam int c_cmp_w  = NUM_DECODE + 1;

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nchunk - 1);
    localparam logic [c_cmp_w-1:0] c_taps = c_cmp_w'(NUM_TAPS);

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_chunk;
    logic [c_cmp_w-1:0]  r_nsat;
    logic [NUM_TAPS-1:0] r_work;
    logic [NUM_TAPS-1:0] r_out;
    logic                r_busy;
    logic                r_finished;

    logic [c_cmp_w-1:0]  w_req;
    logic [c_cmp_w-1:0]  w_base;
    logic [CHUNK-1:0]    w_mask;

    assign w_req  = {1'b0, bus.wEncodeIn};
    // Constant-factor scale of the chunk counter; reduces to shifts/adds.
    assign w_base = c_cmp_w'(r_chunk) * c_cmp_w'(CHUNK);

    thermo_chunk #(
        .NUM_TAPS (NUM_TAPS),
        .CMP_W    (c_cmp_w),
        .CHUNK    (CHUNK)
    ) u_chunk (
        .i_base    (w_base),
        .i_nsat    (r_nsat),
        .i_falling (FALLING),
        .o_mask    (w_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_chunk    <= '0;
            r_nsat     <= '0;
            r_work     <= '0;
            r_out      <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.go) begin
                        r_nsat  <= (w_req > c_taps) ? c_taps : w_req;
                        r_work  <= '0;
                        r_chunk <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Taps past the end of the chain have no storage.
                    for (int i = 0; i < CHUNK; i++) begin
                        if (int'(w_base) + i < NUM_TAPS) begin
                            r_work[int'(w_base) + i] <= w_mask[i];
                        end
                    end
                    if (r_chunk == c_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_chunk <= r_chunk + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_out      <= r_work;
                    r_finished <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.finished   = r_finished;
    assign bus.wEncodeOut = r_out;

endmodule
`default_nettype wire

// File: tb/tb_thermo_encode.sv
`default_nettype none
// ============================================================================
// Module   : tb_thermo_encode
// Purpose  : Self-checking bench driving rising and falling encoders in step.
// Revision : 1.0  initial release
// ============================================================================
module tb_thermo_encode;
    import tdc_pkg::*;

    localparam int NT = c_num_taps;
    localparam int ND = c_num_decode;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    thermo_encode_if #(.NUM_TAPS(NT), .NUM_DECODE(ND)) bus_r ();
    thermo_encode_if #(.NUM_TAPS(NT), .NUM_DECODE(ND)) bus_f ();

    thermo_encode #(.NUM_TAPS(NT), .NUM_DECODE(ND), .CHUNK(c_chunk), .FALLING(1'b0))
        dut_r (.clk(clk), .rst(rst), .bus(bus_r));
    thermo_encode #(.NUM_TAPS(NT), .NUM_DECODE(ND), .CHUNK(c_chunk), .FALLING(1'b1))
        dut_f (.clk(clk), .rst(rst), .bus(bus_f));

    int checks   = 0;
    int failures = 0;
    int fin_r    = 0;
    int fin_f    = 0;

    always @(posedge clk) begin
        #2;
        if (bus_r.finished === 1'b1) fin_r++;
        if (bus_f.finished === 1'b1) fin_f++;
    end

    typedef struct {
        int          n;
        logic [15:0] r_lo;
        logic [15:0] f_hi;
        int          pop;
    } vec_t;

    task automatic check(input string name, input logic [NT-1:0] got, input logic [NT-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Independent shift-based model of the expected word.
    function automatic logic [NT-1:0] model(input int n, input bit fall);
        logic [NT-1:0] ones = '1;
        if (n >= NT) return ones;
        return fall ? ~(ones >> n) : ~(ones << n);
    endfunction

    // Decoder-style count of contiguous ones from the fill end.
    function automatic int decode(input logic [NT-1:0] w, input bit fall);
        int c = 0;
        for (int i = 0; i < NT; i++) begin
            if (w[fall ? NT - 1 - i : i]) c++;
            else break;
        end
        return c;
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge E0.
    task automatic pulse_go(input int n);
        bus_r.go = 1'b1; bus_r.wEncodeIn = ND'(n);
        bus_f.go = 1'b1; bus_f.wEncodeIn = ND'(n);
        @(negedge clk);
        bus_r.go = 1'b0;
        bus_f.go = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus_r.finished !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic convert(input int n, output int lat);
        pulse_go(n);
        wait_done(lat);
    endtask

    vec_t tbl[10];
    int   lat;
    int   fs_r;
    int   fs_f;
    bit   bsy_ok;
    bit   part_ok;

    initial begin
        bus_r.go = 1'b0; bus_r.wEncodeIn = '0;
        bus_f.go = 1'b0; bus_f.wEncodeIn = '0;

        tbl[0] = '{0,    16'h0000, 16'h0000, 0};
        tbl[1] = '{1,    16'h0001, 16'h8000, 1};
        tbl[2] = '{11,   16'h07FF, 16'hFFE0, 11};
        tbl[3] = '{16,   16'hFFFF, 16'hFFFF, 16};
        tbl[4] = '{32,   16'hFFFF, 16'hFFFF, 32};
        tbl[5] = '{33,   16'hFFFF, 16'hFFFF, 33};
        tbl[6] = '{289,  16'hFFFF, 16'hFFFF, 289};
        tbl[7] = '{299,  16'hFFFF, 16'hFFFF, 299};
        tbl[8] = '{300,  16'hFFFF, 16'hFFFF, 300};
        tbl[9] = '{1023, 16'hFFFF, 16'hFFFF, 300};

        // Reset, then idle with go low.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_out_r", bus_r.wEncodeOut, '0);
        check("reset_out_f", bus_f.wEncodeOut, '0);
        check("reset_busy_fin", {bus_r.busy, bus_r.finished, bus_f.busy, bus_f.finished}, '0);
        repeat (20) @(negedge clk);
        check("idle_out", {bus_r.wEncodeOut, bus_f.wEncodeOut} != '0, 1'b0);
        check("idle_no_finish", fin_r + fin_f, 0);

        // N=5: latency, busy window, no partial results, single pulse.
        pulse_go(5);
        bsy_ok  = 1'b1;
        part_ok = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (bus_r.busy !== 1'b1 || bus_f.busy !== 1'b1) bsy_ok = 1'b0;
            if (bus_r.finished !== 1'b0 || bus_r.wEncodeOut !== '0 || bus_f.wEncodeOut !== '0)
                part_ok = 1'b0;
            @(negedge clk);
        end
        check("busy_e1_e11", bsy_ok, 1'b1);
        check("no_partial", part_ok, 1'b1);
        check("finish_at_e11", {bus_r.finished, bus_f.finished}, 2'b11);
        check("busy_low_done", {bus_r.busy, bus_f.busy}, 2'b00);
        check("n5_rise", bus_r.wEncodeOut, model(5, 1'b0));
        check("n5_fall", bus_f.wEncodeOut, model(5, 1'b1));
        @(negedge clk);
        check("finish_one_cycle", {bus_r.finished, bus_f.finished}, 2'b00);
        check("n5_held", bus_r.wEncodeOut, model(5, 1'b0));

        // Table of directed counts; back-to-back conversions.
        for (int v = 0; v < 10; v++) begin
            convert(tbl[v].n, lat);
            check($sformatf("tbl%0d_latency", v), lat, 11);
            check($sformatf("tbl%0d_rise_lo", v), bus_r.wEncodeOut[15:0], tbl[v].r_lo);
            check($sformatf("tbl%0d_fall_hi", v), bus_f.wEncodeOut[NT-1 -: 16], tbl[v].f_hi);
            check($sformatf("tbl%0d_pop_r", v), $countones(bus_r.wEncodeOut), tbl[v].pop);
            check($sformatf("tbl%0d_pop_f", v), $countones(bus_f.wEncodeOut), tbl[v].pop);
            check($sformatf("tbl%0d_word_r", v), bus_r.wEncodeOut, model(tbl[v].n, 1'b0));
            check($sformatf("tbl%0d_word_f", v), bus_f.wEncodeOut, model(tbl[v].n, 1'b1));
        end

        // Sweep through a decoder model.
        for (int n = 0; n <= NT; n++) begin
            convert(n, lat);
            check($sformatf("sweep%0d_latency", n), lat, 11);
            check($sformatf("sweep%0d_dec_r", n), decode(bus_r.wEncodeOut, 1'b0), n);
            check($sformatf("sweep%0d_dec_f", n), decode(bus_f.wEncodeOut, 1'b1), n);
            check($sformatf("sweep%0d_pop", n),
                  {$countones(bus_r.wEncodeOut), $countones(bus_f.wEncodeOut)}, {n, n});
        end

        // go while busy is ignored.
        @(negedge clk);
        fs_r = fin_r;
        fs_f = fin_f;
        pulse_go(3);
        repeat (3) @(negedge clk);
        pulse_go(7);
        wait_done(lat);
        check("busy_go_done_seen", lat < 40, 1'b1);
        check("busy_go_word_r", bus_r.wEncodeOut, model(3, 1'b0));
        check("busy_go_word_f", bus_f.wEncodeOut, model(3, 1'b1));
        repeat (14) @(negedge clk);
        check("busy_go_single_pulse", {fin_r - fs_r, fin_f - fs_f}, {32'd1, 32'd1});
        check("busy_go_idle", {bus_r.busy, bus_f.busy}, 2'b00);

        // rst at E5 aborts; go at E7 completes normally.
        fs_r = fin_r;
        pulse_go(9);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out", {bus_r.wEncodeOut, bus_f.wEncodeOut}, '0);
        check("abort_busy_fin", {bus_r.busy, bus_r.finished, bus_f.busy, bus_f.finished}, '0);
        @(negedge clk);
        pulse_go(9);
        wait_done(lat);
        check("after_abort_latency", lat, 11);
        check("after_abort_word_r", bus_r.wEncodeOut, model(9, 1'b0));
        check("after_abort_word_f", bus_f.wEncodeOut, model(9, 1'b1));
        check("abort_no_extra_pulse", fin_r - fs_r, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
